// File: rtl/imem_load_ctrl_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory boot loader.
package imem_load_ctrl_pkg;

    localparam int CPU_WIDTH           = 32;
    localparam int INST_MEM_ADDR_DEPTH = 4096;

    typedef enum logic [1:0] {
        IMEM_LD_IDLE = 2'd0,
        IMEM_LD_LOAD = 2'd1,
        IMEM_LD_DONE = 2'd2
    } imem_ld_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles a byte stream into little-endian words; word_vld pulses for one cycle
// after the final byte of each word has been accepted.
module imem_word_packer
    import imem_load_ctrl_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             byte_take,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word,
    output logic             word_vld
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    logic [CW-1:0]    byte_cnt;
    logic [WIDTH-9:0] asm_q;

    // The top byte goes straight into the output word, so the assembly register
    // only holds the lower bytes and is free to start the next word immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            asm_q    <= '0;
            word     <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
                asm_q    <= '0;
            end else if (byte_take) begin
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                    word     <= {byte_i, asm_q};
                    word_vld <= 1'b1;
                end else begin
                    asm_q[8*byte_cnt +: 8] <= byte_i;
                    byte_cnt               <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot-time instruction-memory loader: packs bytes into words, writes them at consecutive
// addresses, then hands the address port to the core PC. `IMEM_LOAD_CSUM_EN adds a checksum.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int WIDTH     = CPU_WIDTH,
    parameter int DEPTH     = INST_MEM_ADDR_DEPTH,
    parameter bit BOOT_HOLD = 1'b1
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_start_i,
    input  logic [$clog2(DEPTH):0] load_len_i,
    input  logic                   byte_vld_i,
    input  logic [7:0]             byte_i,
    output logic                   byte_rdy_o,
    input  logic [WIDTH-1:0]       pc_i,
`ifdef IMEM_LOAD_CSUM_EN
    input  logic [WIDTH-1:0]       csum_i,
`endif
    output logic                   mem_wr_en_o,
    output logic [WIDTH-1:0]       mem_data_o,
    output logic [WIDTH-1:0]       mem_addr_o,
    output logic                   cpu_hold_o,
    output logic                   load_busy_o,
    output logic                   load_done_o,
    output logic                   load_err_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int ALSB = $clog2(WIDTH / 8);

    imem_ld_state_e   state, state_nxt;
    logic [AW-1:0]    word_addr;
    logic [LW-1:0]    len_q;
    logic             err_q;
    logic             hold_q;
    logic             start_acc;
    logic             len_zero;
    logic             len_over;
    logic             last_word;
    logic             byte_take;
    logic             word_vld;
    logic             csum_bad;
    logic [WIDTH-1:0] packed_word;
    logic [WIDTH-1:0] ld_addr;

    assign start_acc  = (state == IMEM_LD_IDLE) && load_start_i;
    assign len_zero   = (load_len_i == '0);
    assign len_over   = (load_len_i > LW'(DEPTH));
    assign last_word  = ({1'b0, word_addr} == (len_q - 1'b1));
    assign byte_take  = byte_vld_i && byte_rdy_o;
    assign mem_data_o = packed_word;

    imem_word_packer #(
        .WIDTH(WIDTH)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_acc),
        .byte_take(byte_take),
        .byte_i   (byte_i),
        .word     (packed_word),
        .word_vld (word_vld)
    );

    always_comb begin
        ld_addr                   = '0;
        ld_addr[AW+ALSB-1:ALSB]   = word_addr;
    end

`ifdef IMEM_LOAD_CSUM_EN
    logic [WIDTH-1:0] csum_q;
    logic [WIDTH-1:0] sum_q;

    // Running sum tracks exactly what was written, so it is ready on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
            sum_q  <= '0;
        end else if (start_acc && !len_over) begin
            csum_q <= csum_i;
            sum_q  <= '0;
        end else if (mem_wr_en_o) begin
            sum_q <= sum_q + packed_word;
        end
    end

    assign csum_bad = (state == IMEM_LD_DONE) && (sum_q != csum_q);
`else
    assign csum_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IMEM_LD_IDLE;
            word_addr <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            hold_q    <= BOOT_HOLD;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                if (len_over) begin
                    err_q <= 1'b1;
                end else begin
                    err_q     <= 1'b0;
                    len_q     <= load_len_i;
                    word_addr <= '0;
                end
            end
            if (mem_wr_en_o) begin
                word_addr <= word_addr + 1'b1;
            end
            if (state == IMEM_LD_DONE) begin
                hold_q <= csum_bad;
                if (csum_bad) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Ready drops during the final word's write cycle so no byte past the load is consumed.
    always_comb begin
        state_nxt   = state;
        byte_rdy_o  = 1'b0;
        load_busy_o = 1'b0;
        load_done_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = pc_i;
        cpu_hold_o  = hold_q;
        load_err_o  = err_q | csum_bad;
        case (state)
            IMEM_LD_IDLE: begin
                if (start_acc && !len_over) begin
                    state_nxt = len_zero ? IMEM_LD_DONE : IMEM_LD_LOAD;
                end
            end
            IMEM_LD_LOAD: begin
                load_busy_o = 1'b1;
                cpu_hold_o  = 1'b1;
                byte_rdy_o  = !(word_vld && last_word);
                mem_wr_en_o = word_vld;
                mem_addr_o  = ld_addr;
                if (word_vld && last_word) begin
                    state_nxt = IMEM_LD_DONE;
                end
            end
            IMEM_LD_DONE: begin
                load_done_o = 1'b1;
                cpu_hold_o  = csum_bad;
                state_nxt   = IMEM_LD_IDLE;
            end
            default: begin
                state_nxt = IMEM_LD_IDLE;
            end
        endcase
    end

endmodule
